pm_byte_loader: RTL and testbench

//  Upstream feeder for the CPU program memory. Accepts a byte stream from the 8-bit pad bus,

---
 rtl/pm_byte_loader.sv | 155 +++++++++++++++
 tb/tb_pm_byte_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pm_byte_loader.sv
//==============================================================================
// Module   : pm_byte_loader
// Brief    : Assembles a byte stream into little-endian words and writes them
//            to program memory at auto-incrementing addresses.
//            Optional running XOR checksum: define PM_LOADER_CHECKSUM_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module pm_byte_loader #(
    parameter int DATAWIDTH = 32,
    parameter int ADDWIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic [ADDWIDTH-1:0]  base_addr,
    input  logic [ADDWIDTH:0]    word_count,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 pm_wr_en,
    output logic [ADDWIDTH-1:0]  pm_addr,
    output logic [DATAWIDTH-1:0] pm_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           checksum
);

    localparam int BYTES = DATAWIDTH / 8;
    localparam int CNTW  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNTW-1:0]      cnt_q,   cnt_d;
    logic [ADDWIDTH:0]    rem_q,   rem_d;
    logic [ADDWIDTH-1:0]  addr_q,  addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic                 err_q,   err_d;

    logic accept_w;
    logic start_w;

    assign byte_ready = (state_q == S_LOAD);
    assign pm_wr_en   = (state_q == S_WRITE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign pm_addr    = addr_q;
    assign pm_wdata   = wdata_q;

    assign accept_w = byte_valid && byte_ready;
    // load_start only counts when no session is in flight
    assign start_w  = load_start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_w) begin
                    addr_d  = base_addr;
                    rem_d   = word_count;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (word_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept_w) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (cnt_q == CNTW'(k)) begin
                            wdata_d[8*k +: 8] = byte_in;
                        end
                    end
                    if (cnt_q == CNTW'(BYTES - 1)) begin
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                cnt_d   = '0;
                state_d = (rem_q == {{ADDWIDTH{1'b0}}, 1'b1}) ? S_DONE : S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A dropped byte outranks the clear from a simultaneous load_start
        if (byte_valid && !byte_ready) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

`ifdef PM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_w) begin
            csum_d = 8'h00;
        end else if (accept_w) begin
            csum_d = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pm_byte_loader.sv
//==============================================================================
// Module   : tb_pm_byte_loader
// Brief    : Scoreboard bench for pm_byte_loader (DATAWIDTH=32, ADDWIDTH=7).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_pm_byte_loader;

    localparam int DW = 32;
    localparam int AW = 7;
`ifdef PM_LOADER_CHECKSUM_EN
    localparam logic [7:0] C_T1_CSUM = 8'h06;
`else
    localparam logic [7:0] C_T1_CSUM = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          pm_wr_en;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] pm_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    checksum;

    int n_checks   = 0;
    int n_failures = 0;
    int n_writes   = 0;
    int exp_writes = 0;

    logic [AW+DW-1:0] sb_q[$];

    pm_byte_loader #(.DATAWIDTH(DW), .ADDWIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pm_wr_en   (pm_wr_en),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && pm_wr_en) begin
            n_writes++;
            check("wr_byte_ready_low", byte_ready, 1'b0);
            if (sb_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                logic [AW+DW-1:0] e;
                e = sb_q.pop_front();
                check("wr_addr", pm_addr, e[AW+DW-1:DW]);
                check("wr_data", pm_wdata, e[DW-1:0]);
            end
        end
    end

    task automatic start(input logic [AW-1:0] b, input logic [AW:0] c);
        @(negedge clk);
        load_start = 1'b1;
        base_addr  = b;
        word_count = c;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        for (int i = 0; i < 20 && !sent; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                byte_valid = 1'b1;
                byte_in    = b;
                @(posedge clk); #1;
                byte_valid = 1'b0;
                sent       = 1'b1;
            end
        end
        if (!sent) check("byte_timeout", 1'b1, 1'b0);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] w);
        sb_q.push_back({a, w});
        exp_writes++;
        for (int k = 0; k < DW/8; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; base_addr = '0; word_count = '0;
        byte_in = '0; byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {byte_ready, pm_wr_en, busy, done, err}, 5'b0);
        check("rst_addr", pm_addr, '0);
        check("rst_wdata", pm_wdata, '0);
        check("rst_csum", checksum, 8'h00);
        rst = 1'b0;

        // 1: single word, latency and done timing
        start(7'd5, 8'd1);
        sb_q.push_back({7'd5, 32'h00100513});
        exp_writes++;
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
        @(negedge clk);
        check("t1_wr_latency", pm_wr_en, 1'b1);
        @(negedge clk);
        check("t1_done", done, 1'b1);
        check("t1_busy", busy, 1'b0);
        check("t1_csum", checksum, C_T1_CSUM);
        check("t1_err", err, 1'b0);
        check("t1_wdata_hold", pm_wdata, 32'h00100513);

        // 2: address wrap across the top of memory
        start(7'd126, 8'd3);
        send_word(7'd126, 32'hDEADBEEF);
        send_word(7'd127, 32'h01234567);
        send_word(7'd0,   32'hA5A55A5A);
        wait_done("t2_done");
        check("t2_err", err, 1'b0);
        check("t2_addr_after", pm_addr, 7'd1);

        // 3: byte offered during WRITE is dropped and flags err
        start(7'd10, 8'd2);
        send_word(7'd10, 32'h11223344);
        byte_valid = 1'b1; byte_in = 8'hEE;
        @(negedge clk);
        check("t3_in_write", pm_wr_en, 1'b1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        check("t3_err", err, 1'b1);
        send_word(7'd11, 32'hCAFEF00D);
        wait_done("t3_done");
        check("t3_err_sticky", err, 1'b1);
        start(7'd0, 8'd0);
        @(negedge clk);
        check("t3_err_cleared", err, 1'b0);

        // 4: async reset mid-word
        start(7'd40, 8'd1);
        send_byte(8'hAA); send_byte(8'hBB);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_async", {byte_ready, pm_wr_en, busy, done, err}, 5'b0);
        check("t4_rst_wdata", pm_wdata, '0);
        check("t4_rst_addr", pm_addr, '0);
        @(negedge clk);
        rst = 1'b0;
        start(7'd0, 8'd1);
        send_word(7'd0, 32'h87654321);
        wait_done("t4_done");

        // 5: zero-length session, then load_start while busy
        start(7'd33, 8'd0);
        @(negedge clk);
        check("t5_zero_done", done, 1'b1);
        check("t5_zero_busy", busy, 1'b0);
        start(7'd20, 8'd1);
        sb_q.push_back({7'd20, 32'h0BADC0DE});
        exp_writes++;
        send_byte(8'hDE); send_byte(8'hC0);
        start(7'd50, 8'd3);
        check("t5_still_busy", busy, 1'b1);
        send_byte(8'hAD); send_byte(8'h0B);
        wait_done("t5_done");
        check("t5_err", err, 1'b0);
        check("t5_addr_after", pm_addr, 7'd21);

        repeat (3) @(negedge clk);
        check("write_count", n_writes, exp_writes);
        check("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

`default_nettype wire
